// File: rtl/serial_pkg.sv
// Shared definitions for the serial I/O transmit and receive blocks.
package serial_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/counter8.sv
// Free-running 3-bit counter with synchronous clear and count enable.
module counter8 (
  input  logic       clk,
  input  logic       en,
  input  logic       rst,
  output logic [2:0] y
);

  always_ff @(posedge clk) begin
    if (rst) begin
      y <= 3'd0;
    end else if (en) begin
      y <= y + 3'd1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// 8N1 transmit sequencer: accepts a byte on a valid/ready handshake and
// serialises it onto txd as start bit, 8 data bits LSB first, stop bit.
module uart_tx_ctrl
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_t            state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 tick;
  logic                 accept;
  logic                 idx_en;
  logic                 idx_rst;

  assign tick    = (baud_cnt == CNT_LAST);
  assign accept  = tx_valid && tx_ready;
  assign idx_en  = (state == DATA) && tick;
  assign idx_rst = rst || accept;

  // Baud divider: parked at zero while idle so every frame starts aligned.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      baud_cnt <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  counter8 u_bit_idx (
    .clk (clk),
    .en  (idx_en),
    .rst (idx_rst),
    .y   (bit_idx)
  );

  // Frame sequencer; txd always carries the bit for the cycle after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      shreg    <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= tx_data;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            txd   <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg >> 1;
            if (bit_idx == IDX_LAST) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd <= shreg[1];
            end
          end
        end
        STOP: begin
          // Registered pulse lands on the final stop-bit cycle.
          if (baud_cnt == CNT_PRE) begin
            tx_done <= 1'b1;
          end
          if (tick) begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl at CLKS_PER_BIT=4 and the minimum of 2.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, valid4, ready4, txd4, busy4, done4;
  logic [7:0] data4;
  logic       rst2, valid2, ready2, txd2, busy2, done2;
  logic [7:0] data2;

  uart_tx_ctrl #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst4), .tx_data(data4), .tx_valid(valid4),
    .tx_ready(ready4), .txd(txd4), .busy(busy4), .tx_done(done4)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst2), .tx_data(data2), .tx_valid(valid2),
    .tx_ready(ready2), .txd(txd2), .busy(busy2), .tx_done(done2)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic cap_txd   [0:511];
  logic cap_done  [0:511];
  logic cap_ready [0:511];
  logic cap_busy  [0:511];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record n cycles of outputs starting at index 'from' (index 0 = cycle after accept).
  task automatic capture(input bit sel, input int from, input int n);
    for (int i = 0; i < n; i++) begin
      cap_txd[from+i]   = sel ? txd2   : txd4;
      cap_done[from+i]  = sel ? done2  : done4;
      cap_ready[from+i] = sel ? ready2 : ready4;
      cap_busy[from+i]  = sel ? busy2  : busy4;
      step();
    end
  endtask

  // Wait for ready, present a byte, and return positioned at cycle 0 of the frame.
  task automatic send(input bit sel, input logic [7:0] b, input bit hold);
    int w = 0;
    while (((sel ? ready2 : ready4) !== 1'b1) && w < 100) begin
      step();
      w++;
    end
    tests_run++;
    if (w >= 100) begin
      tests_failed++;
      $display("FAIL send_wait_ready: tx_ready still %b after 100 cycles, required 1",
               sel ? ready2 : ready4);
    end
    if (sel) begin data2 = b; valid2 = 1'b1; end
    else     begin data4 = b; valid4 = 1'b1; end
    step();
    if (!hold) begin
      if (sel) valid2 = 1'b0;
      else     valid4 = 1'b0;
    end
  endtask

  // Ideal line level of one 8N1 frame, cycle 0 = first start-bit cycle.
  function automatic logic frame_bit(input logic [7:0] b, input int c, input int cyc);
    int k;
    k = cyc / c;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Line model for one frame, or two frames separated by a single idle cycle.
  function automatic logic exp_txd(input logic [7:0] b0, input logic [7:0] b1,
                                   input bit two, input int c, input int cyc);
    int len;
    len = 10 * c;
    if (!two || cyc <= len) return frame_bit(b0, c, cyc);
    return frame_bit(b1, c, cyc - len - 1);
  endfunction

  function automatic logic exp_done(input bit two, input int c, input int cyc);
    return (cyc == 10*c - 1) || (two && cyc == 20*c);
  endfunction

  function automatic logic exp_ready(input bit two, input int c, input int cyc);
    if (two) return (cyc == 10*c) || (cyc >= 20*c + 1);
    return cyc >= 10*c;
  endfunction

  task automatic test_reset();
    rst4 = 1'b1; rst2 = 1'b1;
    valid4 = 1'b0; valid2 = 1'b0;
    data4 = 8'h00; data2 = 8'h00;
    repeat (3) step();
    rst4 = 1'b0; rst2 = 1'b0;
    tests_run++;
    if ({txd4, ready4, busy4, done4} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_outputs4: txd/ready/busy/done=%b required 1100",
               {txd4, ready4, busy4, done4});
    end
    tests_run++;
    if ({txd2, ready2, busy2, done2} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_outputs2: txd/ready/busy/done=%b required 1100",
               {txd2, ready2, busy2, done2});
    end
    for (int i = 0; i < 8; i++) begin
      step();
      tests_run++;
      if ({txd4, ready4, done4} !== 3'b110) begin
        tests_failed++;
        $display("FAIL reset_idle cyc %0d: txd/ready/done=%b required 110", i, {txd4, ready4, done4});
      end
    end
  endtask

  task automatic test_single_byte();
    send(1'b0, 8'hA5, 1'b0);
    capture(1'b0, 0, 44);
    for (int i = 0; i < 44; i++) begin
      tests_run++;
      if (cap_txd[i] !== exp_txd(8'hA5, 8'h00, 1'b0, 4, i) ||
          cap_done[i] !== exp_done(1'b0, 4, i) ||
          cap_ready[i] !== exp_ready(1'b0, 4, i) ||
          cap_busy[i] !== !exp_ready(1'b0, 4, i)) begin
        tests_failed++;
        $display("FAIL single_A5 cyc %0d: txd=%b done=%b ready=%b busy=%b required %b %b %b %b", i,
                 cap_txd[i], cap_done[i], cap_ready[i], cap_busy[i],
                 exp_txd(8'hA5, 8'h00, 1'b0, 4, i), exp_done(1'b0, 4, i),
                 exp_ready(1'b0, 4, i), !exp_ready(1'b0, 4, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int fall;
    send(1'b0, 8'h00, 1'b1);
    data4 = 8'hFF;
    capture(1'b0, 0, 41);
    valid4 = 1'b0;
    capture(1'b0, 41, 43);
    for (int i = 0; i < 84; i++) begin
      tests_run++;
      if (cap_txd[i] !== exp_txd(8'h00, 8'hFF, 1'b1, 4, i) ||
          cap_done[i] !== exp_done(1'b1, 4, i) ||
          cap_ready[i] !== exp_ready(1'b1, 4, i)) begin
        tests_failed++;
        $display("FAIL b2b cyc %0d: txd=%b done=%b ready=%b required %b %b %b", i,
                 cap_txd[i], cap_done[i], cap_ready[i],
                 exp_txd(8'h00, 8'hFF, 1'b1, 4, i), exp_done(1'b1, 4, i), exp_ready(1'b1, 4, i));
      end
    end
    fall = -1;
    for (int i = 40; i < 84; i++) begin
      if (fall < 0 && cap_txd[i] === 1'b0) fall = i;
    end
    tests_run++;
    if (fall != 41) begin
      tests_failed++;
      $display("FAIL b2b_start_spacing: second start at cycle %0d required 41", fall);
    end
  endtask

  task automatic test_ignored_while_busy();
    send(1'b0, 8'h3C, 1'b0);
    capture(1'b0, 0, 12);
    data4 = 8'h55;
    valid4 = 1'b1;
    capture(1'b0, 12, 29);
    valid4 = 1'b0;
    capture(1'b0, 41, 43);
    for (int i = 0; i < 84; i++) begin
      tests_run++;
      if (cap_txd[i] !== exp_txd(8'h3C, 8'h55, 1'b1, 4, i) ||
          cap_done[i] !== exp_done(1'b1, 4, i) ||
          cap_ready[i] !== exp_ready(1'b1, 4, i)) begin
        tests_failed++;
        $display("FAIL busy_ignore cyc %0d: txd=%b done=%b ready=%b required %b %b %b", i,
                 cap_txd[i], cap_done[i], cap_ready[i],
                 exp_txd(8'h3C, 8'h55, 1'b1, 4, i), exp_done(1'b1, 4, i), exp_ready(1'b1, 4, i));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    send(1'b0, 8'h0F, 1'b0);
    capture(1'b0, 0, 18);
    rst4 = 1'b1;
    step();
    tests_run++;
    if ({txd4, done4, busy4} !== 3'b100) begin
      tests_failed++;
      $display("FAIL midreset_edge: txd/done/busy=%b required 100", {txd4, done4, busy4});
    end
    step();
    rst4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({txd4, ready4, done4} !== 3'b110) begin
        tests_failed++;
        $display("FAIL midreset_after cyc %0d: txd/ready/done=%b required 110", i, {txd4, ready4, done4});
      end
      step();
    end
    // Reset coincident with a handshake drops the byte.
    rst4 = 1'b1; data4 = 8'h00; valid4 = 1'b1;
    step();
    rst4 = 1'b0; valid4 = 1'b0;
    step();
    tests_run++;
    if ({txd4, ready4} !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_vs_accept: txd/ready=%b required 11", {txd4, ready4});
    end
    send(1'b0, 8'h81, 1'b0);
    capture(1'b0, 0, 42);
    for (int i = 0; i < 42; i++) begin
      tests_run++;
      if (cap_txd[i] !== exp_txd(8'h81, 8'h00, 1'b0, 4, i) ||
          cap_done[i] !== exp_done(1'b0, 4, i) ||
          cap_ready[i] !== exp_ready(1'b0, 4, i)) begin
        tests_failed++;
        $display("FAIL after_reset_81 cyc %0d: txd=%b done=%b ready=%b required %b %b %b", i,
                 cap_txd[i], cap_done[i], cap_ready[i],
                 exp_txd(8'h81, 8'h00, 1'b0, 4, i), exp_done(1'b0, 4, i), exp_ready(1'b0, 4, i));
      end
    end
  endtask

  task automatic test_min_divider();
    int first_ready;
    send(1'b1, 8'h01, 1'b0);
    capture(1'b1, 0, 24);
    for (int i = 0; i < 24; i++) begin
      tests_run++;
      if (cap_txd[i] !== exp_txd(8'h01, 8'h00, 1'b0, 2, i) ||
          cap_done[i] !== exp_done(1'b0, 2, i) ||
          cap_ready[i] !== exp_ready(1'b0, 2, i)) begin
        tests_failed++;
        $display("FAIL min_div cyc %0d: txd=%b done=%b ready=%b required %b %b %b", i,
                 cap_txd[i], cap_done[i], cap_ready[i],
                 exp_txd(8'h01, 8'h00, 1'b0, 2, i), exp_done(1'b0, 2, i), exp_ready(1'b0, 2, i));
      end
    end
    first_ready = -1;
    for (int i = 0; i < 24; i++) begin
      if (first_ready < 0 && cap_ready[i] === 1'b1) first_ready = i;
    end
    tests_run++;
    if (first_ready != 20) begin
      tests_failed++;
      $display("FAIL min_div_length: frame length %0d required 20", first_ready);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [7:0] b;
      bit sel;
      int c;
      b   = 8'($urandom);
      sel = it[0];
      c   = sel ? 2 : 4;
      send(sel, b, 1'b0);
      capture(sel, 0, 10*c + 3);
      for (int i = 0; i < 10*c + 3; i++) begin
        tests_run++;
        if (cap_txd[i] !== exp_txd(b, 8'h00, 1'b0, c, i) ||
            cap_done[i] !== exp_done(1'b0, c, i) ||
            cap_ready[i] !== exp_ready(1'b0, c, i)) begin
          tests_failed++;
          $display("FAIL random byte %02h div %0d cyc %0d: txd=%b done=%b ready=%b required %b %b %b",
                   b, c, i, cap_txd[i], cap_done[i], cap_ready[i],
                   exp_txd(b, 8'h00, 1'b0, c, i), exp_done(1'b0, c, i), exp_ready(1'b0, c, i));
        end
      end
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_ignored_while_busy();
    test_reset_mid_frame();
    test_min_divider();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side sequencer for the serial I/O device. It accepts one byte over a valid/ready handshake and drives the 8N1 line frame onto `txd`: start bit, 8 data bits LSB first, stop bit. A baud divider times each bit, and a 3-bit bit-index counter steps through the data bits. It sits between the CPU-side serial register interface and the TX pin.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): clock cycles per line bit. Legal range is 2 or more.
- `clk` in 1: system clock; all logic on the posedge.
- `rst` in 1: synchronous, active-high reset.
- `tx_data` in 8: byte to send; sampled only on the accept cycle.
- `tx_valid` in 1: requester has a byte.
- `tx_ready` out 1: controller can accept; equals (state == IDLE).
- `txd` out 1: serial line output, registered; idle level 1.
- `busy` out 1: frame in progress; equals !tx_ready.
- `tx_done` out 1: one-cycle pulse on the final cycle of the stop bit.

## Operation
- FSM states are IDLE, START, DATA, STOP.
- **IDLE**
  - `txd`=1.
  - On `tx_valid && tx_ready`: latch `tx_data` into the shift register, clear the baud and bit counters, go to START.
- **START**
  - `txd`=0 for CLKS_PER_BIT cycles.
  - On the baud tick, go to DATA.
- **DATA**
  - `txd`=shreg[0].
  - On each baud tick, shift right and increment the bit index (counter enable = tick).
  - On the tick with bit index 7, go to STOP. The bit index wraps 7→0.
- **STOP**
  - `txd`=1 for CLKS_PER_BIT cycles.
  - On the tick, assert `tx_done` that cycle and go to IDLE.
- **Baud counter**
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, wraps to 0.
  - tick = (count == CLKS_PER_BIT-1).
  - Held at 0 in IDLE.
- `tx_data` and `tx_valid` are ignored while busy. A byte presented during a frame is not queued; the requester holds `tx_valid` until it sees `tx_ready`.
- **Reset values:** state IDLE, `txd`=1, `tx_ready`=1, `busy`=0, `tx_done`=0, all counters 0, shift register 0.
- **Reset mid-frame:** the frame is aborted. `txd` returns to 1 at the next edge, no `tx_done` is issued, and `tx_ready`=1 once rst deasserts.
- **Reset coincident with a handshake:** reset wins and the byte is dropped.

## Timing
- **Accept cycle:** edge E samples `tx_valid && tx_ready`. `txd` goes low at E (registered output, visible the cycle after the accept cycle).
- Each bit lasts exactly CLKS_PER_BIT cycles.
- The frame occupies 10·CLKS_PER_BIT cycles from E.
- `tx_done` is high during the last cycle of the stop bit. This is cycle 10·CLKS_PER_BIT-1 counted from E (E = cycle 0).
- `tx_ready` rises on the edge ending the stop bit.
- **Back-to-back:** with `tx_valid` held high, the next accept occurs on the first IDLE cycle.
  - The next start bit begins 10·CLKS_PER_BIT+1 cycles after the previous one.
  - This gives exactly one extra idle-high cycle between frames.
- There are no combinational paths from `tx_valid` to any output.

## Structure
- **Shared package `serial_pkg`:**
  - state enum `tx_state_t` {IDLE, START, DATA, STOP};
  - constant `DATA_BITS`=8;
  - default `CLKS_PER_BIT` constant, shared with the future receive block.
- **Bit index:** the team's existing `counter8` module (clk, en, rst, y[2:0]). `en` = (state==DATA && tick); `rst` = `rst` || accept.
- The baud divider is inline in this module; a separate sub-module is not warranted.

## Test plan
- **Reset:** hold `rst` for 3 cycles, then release → `txd`=1, `tx_ready`=1, `busy`=0, `tx_done`=0; the line stays idle with no `tx_valid`.
- **Single byte:** CLKS_PER_BIT=4, send 0xA5.
  - `txd` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - `tx_done` pulses once at cycle 39 after the accept edge.
  - `tx_ready` returns at cycle 40.
- **Back-to-back:** CLKS_PER_BIT=4, `tx_valid` held with 0x00 then 0xFF.
  - Second start bit begins 41 cycles after the first.
  - Exactly one idle-high cycle between the frames.
  - Both bytes decode correctly.
- **Ignored while busy:** CLKS_PER_BIT=4, send 0x3C, then change `tx_data` to 0x55 with `tx_valid` high during DATA.
  - The line carries 0x3C.
  - 0x55 is sent only after `tx_ready` returns.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0x0F.
  - `txd`=1 on the next edge; no `tx_done`.
  - After release, a new byte 0x81 frames correctly.
- **Minimum divider:** CLKS_PER_BIT=2, send 0x01.
  - Start bit low for 2 cycles, then bit0 high for 2 cycles.
  - Frame length is 20 cycles.
